// File: rtl/hf_trans_pkg.sv
// Shared slot-word layout and sequencer state encoding for the hyperfabric
// transport schedule sequencer.
package hf_trans_pkg;

  localparam int SLOT_W   = 32;
  localparam int ISEL_LSB = 0;
  localparam int OSEL_LSB = 16;
  localparam int SEL_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/hf_onehot_chk.sv
// 8-bit zero-or-one-hot detector used on each isel half when
// TRANS_SCHED_CONFLICT_CHK_EN is defined.
module hf_onehot_chk (
  input  logic [7:0] vec,
  output logic       ok
);

  // Clearing the lowest set bit leaves zero only for zero or one-hot input.
  assign ok = ((vec & (vec - 8'd1)) == 8'd0);

endmodule

// File: rtl/hf_trans_sched.sv
// Schedule sequencer driving trans_core select lines; osel lags isel by one slot.
// Optional macro TRANS_SCHED_CONFLICT_CHK_EN enables isel half one-hot checking.
module hf_trans_sched
  import hf_trans_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [SLOT_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [AW:0]       len,
  output logic [SEL_W-1:0]  isel,
  output logic [SEL_W-1:0]  osel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);
  localparam logic [AW:0] ZERO_W  = {(AW+1){1'b0}};

  logic [SLOT_W-1:0] slot_mem [DEPTH];
  state_e            state;
  logic [AW:0]       ptr;
  logic [AW:0]       len_l;
  logic              loop_l;
  logic [SEL_W-1:0]  osel_d;

  logic [AW:0]       len_clamp;
  logic [AW-1:0]     rd_idx;
  logic [SLOT_W-1:0] rd_word;
  logic [SEL_W-1:0]  raw_isel;
  logic [SEL_W-1:0]  rd_osel;
  logic [SEL_W-1:0]  load_isel;
  logic              conflict;
  logic [AW:0]       start_ptr;
  logic [AW:0]       next_ptr;
  logic              pass_end;

  // Slot table; a write and a read of the same slot on one edge yields the old word.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_mem[i] <= {SLOT_W{1'b0}};
      end
    end else if (wr_en) begin
      slot_mem[wr_addr] <= wr_data;
    end
  end

  // Read side: slot 0 while idle, otherwise the pass pointer.
  always_comb begin
    if (len > DEPTH_W) begin
      len_clamp = DEPTH_W;
    end else begin
      len_clamp = len;
    end
    if (state == RUN) begin
      rd_idx = ptr[AW-1:0];
    end else begin
      rd_idx = {AW{1'b0}};
    end
    rd_word  = slot_mem[rd_idx];
    raw_isel = rd_word[ISEL_LSB +: SEL_W];
    rd_osel  = rd_word[OSEL_LSB +: SEL_W];
  end

  // Pointer sequencing; a single-slot looping pass must keep re-reading slot 0.
  always_comb begin
    if (loop && (len_clamp == ONE_W)) begin
      start_ptr = ZERO_W;
    end else begin
      start_ptr = ONE_W;
    end
    if (loop_l && (ptr == (len_l - ONE_W))) begin
      next_ptr = ZERO_W;
    end else begin
      next_ptr = ptr + ONE_W;
    end
    pass_end = (ptr == len_l) && !loop_l;
  end

`ifdef TRANS_SCHED_CONFLICT_CHK_EN
  logic lo_ok;
  logic hi_ok;

  hf_onehot_chk u_chk_lo (.vec(raw_isel[7:0]),  .ok(lo_ok));
  hf_onehot_chk u_chk_hi (.vec(raw_isel[15:8]), .ok(hi_ok));

  // Offending halves are blanked so the crossbar never sees a multi-source select.
  always_comb begin
    load_isel[7:0]  = lo_ok ? raw_isel[7:0]  : 8'h00;
    load_isel[15:8] = hi_ok ? raw_isel[15:8] : 8'h00;
    conflict        = !(lo_ok && hi_ok);
  end
`else
  assign load_isel = raw_isel;
  assign conflict  = 1'b0;
`endif

  // Sequencer FSM and registered select outputs; busy trails state by one cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      ptr    <= ZERO_W;
      len_l  <= ZERO_W;
      loop_l <= 1'b0;
      osel_d <= {SEL_W{1'b0}};
      isel   <= {SEL_W{1'b0}};
      osel   <= {SEL_W{1'b0}};
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (len == ZERO_W) begin
              done <= 1'b1;
            end else begin
              len_l  <= len_clamp;
              loop_l <= loop;
              isel   <= load_isel;
              osel_d <= rd_osel;
              ptr    <= start_ptr;
              err    <= conflict;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          osel <= osel_d;
          if (pass_end || stop) begin
            isel   <= {SEL_W{1'b0}};
            osel_d <= {SEL_W{1'b0}};
            ptr    <= ZERO_W;
            state  <= DRAIN;
          end else begin
            isel   <= load_isel;
            osel_d <= rd_osel;
            ptr    <= next_ptr;
            err    <= err | conflict;
          end
        end
        DRAIN: begin
          osel  <= osel_d;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hf_trans_sched.sv
// Scoreboard bench for hf_trans_sched: stimulus queues per-edge expectations,
// a negedge monitor pops and compares them.
module tb_hf_trans_sched;

  logic        CLK;
  logic        RST;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic        stop;
  logic        loop;
  logic [4:0]  len;
  logic [15:0] isel;
  logic [15:0] osel;
  logic        busy;
  logic        done;
  logic        err;

`ifdef TRANS_SCHED_CONFLICT_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] isel;
    logic [15:0] osel;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_err = 1'b0;

  hf_trans_sched #(.DEPTH(16), .AW(4)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .len(len),
    .isel(isel), .osel(osel), .busy(busy), .done(done), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] slot_isel(input int i);
    if (i < 8) return 16'h0001 << i;
    else       return 16'h0100 << (i - 8);
  endfunction

  function automatic logic [15:0] slot_osel(input int i);
    return 16'hA000 | 16'(i);
  endfunction

  // One clock edge; records what the outputs must show after it.
  task automatic tick(input logic [15:0] ei, input logic [15:0] eo,
                      input logic eb, input logic ed, input string tag);
    exp_t e;
    @(posedge CLK);
    e.isel = ei; e.osel = eo; e.busy = eb; e.done = ed; e.err = exp_err;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "idle_wr");
  endtask

  always @(negedge CLK) begin
    exp_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if ({isel, osel, busy, done, err} !== e) begin
        errors++;
        $display("FAIL %s: got isel=%h osel=%h busy=%b done=%b err=%b, want isel=%h osel=%h busy=%b done=%b err=%b",
                 t, isel, osel, busy, done, err, e.isel, e.osel, e.busy, e.done, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    RST = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; len = 5'd0;
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "reset0");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "reset1");
    RST = 1'b1;

    // Basic two-slot pass
    wr(4'd0, 32'h0300_0201);
    wr(4'd1, 32'h0001_0102);
    start = 1'b1; len = 5'd2; loop = 1'b0;
    tick(16'h0201, 16'h0000, 1'b0, 1'b0, "t1_s0");
    tick(16'h0102, 16'h0300, 1'b1, 1'b0, "t1_s1");
    tick(16'h0000, 16'h0001, 1'b1, 1'b0, "t1_end");
    tick(16'h0000, 16'h0000, 1'b1, 1'b1, "t1_done");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "t1_idle");

    // start together with stop does nothing
    start = 1'b1; stop = 1'b1; len = 5'd2;
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "ss_ign0");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "ss_ign1");

    // Looping pass with wrap, then stop
    wr(4'd0, 32'h0110_1001);
    wr(4'd1, 32'h0220_2002);
    wr(4'd2, 32'h0440_4004);
    start = 1'b1; len = 5'd3; loop = 1'b1;
    tick(16'h1001, 16'h0000, 1'b0, 1'b0, "lp_a0");
    tick(16'h2002, 16'h0110, 1'b1, 1'b0, "lp_b0");
    tick(16'h4004, 16'h0220, 1'b1, 1'b0, "lp_c0");
    tick(16'h1001, 16'h0440, 1'b1, 1'b0, "lp_a1_wrap");
    tick(16'h2002, 16'h0110, 1'b1, 1'b0, "lp_b1");
    stop = 1'b1; loop = 1'b0;
    tick(16'h0000, 16'h0220, 1'b1, 1'b0, "lp_stop");
    tick(16'h0000, 16'h0000, 1'b1, 1'b1, "lp_drain");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "lp_idle");

    // Zero-length start
    start = 1'b1; len = 5'd0;
    tick(16'h0000, 16'h0000, 1'b0, 1'b1, "len0_done");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "len0_idle");

    // len=31 clamps to all 16 slots; a start mid-pass is ignored
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), {slot_osel(i), slot_isel(i)});
    end
    start = 1'b1; len = 5'd31; loop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(slot_isel(i), (i == 0) ? 16'h0000 : slot_osel(i - 1), (i != 0), 1'b0, "clamp_slot");
      if (i == 5) begin
        start = 1'b1; len = 5'd2;
      end
    end
    tick(16'h0000, slot_osel(15), 1'b1, 1'b0, "clamp_end");
    tick(16'h0000, 16'h0000, 1'b1, 1'b1, "clamp_done");

    // Back-to-back start during done; slot1 rewritten on the edge it is read
    start = 1'b1; len = 5'd2;
    tick(slot_isel(0), 16'h0000, 1'b0, 1'b0, "b2b_s0");
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h0BB0_0408;
    tick(slot_isel(1), slot_osel(0), 1'b1, 1'b0, "wr_old");
    tick(16'h0000, slot_osel(1), 1'b1, 1'b0, "wr_end");
    tick(16'h0000, 16'h0000, 1'b1, 1'b1, "wr_done");
    start = 1'b1; len = 5'd2;
    tick(16'h0001, 16'h0000, 1'b0, 1'b0, "p2_s0");
    tick(16'h0408, 16'hA000, 1'b1, 1'b0, "p2_new");
    tick(16'h0000, 16'h0BB0, 1'b1, 1'b0, "p2_end");
    tick(16'h0000, 16'h0000, 1'b1, 1'b1, "p2_done");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "p2_idle");

    // Select conflict on isel[7:0]=0x03
    wr(4'd0, 32'h1234_0003);
    start = 1'b1; len = 5'd1; exp_err = CHK;
    tick(CHK ? 16'h0000 : 16'h0003, 16'h0000, 1'b0, 1'b0, "cf_isel");
    tick(16'h0000, 16'h1234, 1'b1, 1'b0, "cf_end");
    tick(16'h0000, 16'h0000, 1'b1, 1'b1, "cf_done");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "cf_sticky");
    wr(4'd0, 32'h5555_0001);
    start = 1'b1; len = 5'd1; exp_err = 1'b0;
    tick(16'h0001, 16'h0000, 1'b0, 1'b0, "cf_clear");
    tick(16'h0000, 16'h5555, 1'b1, 1'b0, "cf2_end");
    tick(16'h0000, 16'h0000, 1'b1, 1'b1, "cf2_done");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "cf2_idle");

    // Reset mid-run clears outputs and the table
    wr(4'd2, 32'h0000_0300);
    start = 1'b1; len = 5'd4; loop = 1'b1;
    tick(16'h0001, 16'h0000, 1'b0, 1'b0, "rr_s0");
    tick(16'h0408, 16'h5555, 1'b1, 1'b0, "rr_s1");
    exp_err = CHK;
    tick(CHK ? 16'h0000 : 16'h0300, 16'h0BB0, 1'b1, 1'b0, "rr_s2");
    RST = 1'b0; exp_err = 1'b0;
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "rr_reset");
    RST = 1'b1; loop = 1'b0;
    start = 1'b1; len = 5'd3;
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "rr_tbl0");
    tick(16'h0000, 16'h0000, 1'b1, 1'b0, "rr_tbl1");
    tick(16'h0000, 16'h0000, 1'b1, 1'b0, "rr_tbl2");
    tick(16'h0000, 16'h0000, 1'b1, 1'b0, "rr_end");
    tick(16'h0000, 16'h0000, 1'b1, 1'b1, "rr_done");
    tick(16'h0000, 16'h0000, 1'b0, 1'b0, "rr_idle");

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hf_trans_sched.md
# hf_trans_sched

Schedule sequencer that drives the select lines of the hyperfabric transport crossbar (trans_core). Holds a host-loaded table of {osel, isel} slot words. On start it plays DEPTH-bounded passes, one slot per cycle, once or looping. It emits isel and delays osel one cycle so that each slot's output selection meets the crossbar's registered fan stage.

## Interface
- DEPTH, 16: number of table slots.
- AW, 4: table address width, clog2(DEPTH).

- CLK  in  1  clock.
- RST  in  1  reset. Synchronous, active-low; clock CLK.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_data  in  32  slot word. [15:0] = isel, [31:16] = osel.
- start  in  1  begin a schedule pass; IDLE only.
- stop  in  1  abort the pass at the next slot boundary.
- loop  in  1  sampled with start. 1 = wrap to slot 0 forever.
- len  in  AW+1  slots per pass. Sampled with start. 0 = no-op; >DEPTH clamps to DEPTH.
- isel  out  16  crossbar input select.
- osel  out  16  crossbar output enable/mux.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of a pass sequence.
- err  out  1  sticky select-conflict flag (see Configuration).

## Operation
- Table: DEPTH x 32 register array, cleared by reset.
  - Writes are accepted in any state.
  - A same-cycle read of the written address returns the old word.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1, stop=0, len!=0 → latch len (clamped) and loop, then enter RUN. On that same edge: isel←slot[0].isel, osel_d←slot[0].osel, ptr←1.
  - start with len=0 → stays IDLE and pulses done next cycle.
  - start and stop together → stop wins; nothing happens.
- RUN, each edge:
  - osel←osel_d.
  - If ptr==len_l and loop=0, or stop=1: isel←0, osel_d←0, enter DRAIN.
  - Otherwise load slot[ptr]. ptr←ptr+1, or 0 if ptr==len_l−1 and loop=1. The wrap has no bubble.
- DRAIN: osel←osel_d (0), done←1 for one cycle, enter IDLE.
- start while busy is ignored. stop in IDLE or DRAIN is ignored.
- Reset at any point: state←IDLE, ptr←0, table←0. isel, osel, osel_d, busy, done and err all ←0.

## Timing
- Start sampled at edge k:
  - slot i isel is valid after edge k+i.
  - slot i osel is valid after edge k+i+1.
  - The crossbar captures fan data at k+i+1 and writes outputs at k+i+2.
- Non-loop pass of L slots:
  - busy high from k+1 through the cycle after edge k+L+1.
  - done high in the cycle after edge k+L+1.
- stop sampled at edge m in RUN:
  - isel=0 after m.
  - The last osel is still emitted after m, then osel=0 after m+1.
  - done is high in the cycle after m+1.
- Back-to-back passes: start is accepted the same edge done is asserted, because state is IDLE after that edge.

## Configuration
- TRANS_SCHED_CONFLICT_CHK_EN defined:
  - Each loaded slot's isel[7:0] and isel[15:8] must each be zero or one-hot.
  - An offending half is forced to 0 on the isel output, and err←1 on the same edge.
  - err clears only on an accepted start or on reset.
- Not defined: isel passes raw and err is tied 0.
- osel is never checked.

## Structure
- Package hf_trans_pkg holds:
  - SLOT_W=32, ISEL_LSB=0, OSEL_LSB=16, SEL_W=16.
  - the state enum {IDLE, RUN, DRAIN}.
- Sub-module hf_onehot_chk: 8-bit zero-or-one-hot detector, instantiated twice, only under the macro.

## Test plan
- Load slot0={0x0300,0x0201}, slot1={0x0001,0x0102}; start, len=2, loop=0 → isel 0x0201 then 0x0102 then 0. osel 0x0300 one cycle after 0x0201, then 0x0001, then 0. done pulses 3 cycles after start.
- len=3, loop=1, slots 0x11/0x22/0x44 in isel → sequence 11,22,44,11,22… with no gap. Assert stop → isel 0 next cycle, osel 0 one cycle later, then done.
- start with len=0 → busy stays 0 and done pulses once. start with len=31 at DEPTH=16 → 16 slots play.
- With the macro defined, slot0 isel=0x0003 → isel output 0x0000 and err=1. The next accepted start clears err. Without the macro: isel=0x0003 and err=0.
- Write slot1 during RUN at the same edge slot1 is read → old word is emitted; new word appears on the next pass.
- RST low mid-RUN → isel, osel, busy, done, err = 0 next edge. Table reads back 0.
